// File: rtl/gauss5x5_filter_if.sv
// Window-tap / filtered-pixel bundle for gauss5x5_filter.
// The bypass select exists only when GAUSS_BYPASS_EN is defined.
interface gauss5x5_filter_if;
    logic             win_valid;
    logic             win_sof;
    logic [24:0][7:0] w;
`ifdef GAUSS_BYPASS_EN
    logic             bypass;
`endif
    logic [7:0]       pix_out;
    logic             out_valid;
    logic             out_sof;
    logic             out_eol;
    logic             frame_done;

`ifdef GAUSS_BYPASS_EN
    modport master (
        output win_valid, win_sof, w, bypass,
        input  pix_out, out_valid, out_sof, out_eol, frame_done
    );
    modport slave (
        input  win_valid, win_sof, w, bypass,
        output pix_out, out_valid, out_sof, out_eol, frame_done
    );
`else
    modport master (
        output win_valid, win_sof, w,
        input  pix_out, out_valid, out_sof, out_eol, frame_done
    );
    modport slave (
        input  win_valid, win_sof, w,
        output pix_out, out_valid, out_sof, out_eol, frame_done
    );
`endif
endinterface

// File: rtl/gauss5x5_filter.sv
// 3-stage 5x5 binomial smoothing with frame-position tracking.
// Optional GAUSS_BYPASS_EN adds a per-window centre-tap passthrough.
module gauss5x5_filter #(
    parameter int W = 3124,
    parameter int H = 2048
) (
    input  logic             clk,
    input  logic             rst,
    gauss5x5_filter_if.slave bus
);
    localparam int CW = $clog2(W);
    localparam int RW = $clog2(H);

    typedef enum logic {IDLE, ACTIVE} state_t;

    typedef struct packed {
        logic valid;
        logic sof;
        logic eol;
        logic done;
    } mark_t;

    typedef struct packed {
        logic [4:0][11:0] rs;
`ifdef GAUSS_BYPASS_EN
        logic             byp;
        logic [7:0]       ctr;
`endif
    } s1_t;

    typedef struct packed {
        logic [15:0] vs;
`ifdef GAUSS_BYPASS_EN
        logic        byp;
        logic [7:0]  ctr;
`endif
    } s2_t;

    function automatic logic [11:0] hsum(
        input logic [7:0] a, b, c, d, e
    );
        return 12'(a) + 12'(e)
             + ((12'(b) + 12'(d)) << 2)
             + 12'(c) * 12'd6;
    endfunction

    function automatic logic [15:0] vsum(
        input logic [4:0][11:0] r
    );
        return 16'(r[0]) + 16'(r[4])
             + ((16'(r[1]) + 16'(r[3])) << 2)
             + 16'(r[2]) * 16'd6;
    endfunction

    state_t        state, state_nx;
    logic [CW-1:0] col, cur_col;
    logic [RW-1:0] row, cur_row;
    logic          take, last;
    mark_t         m0, m1, m2;
    s1_t           d1;
    s2_t           d2;
    logic [16:0]   rnd;
    logic [7:0]    pix_nx;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:
                if (bus.win_valid && bus.win_sof)
                    state_nx = ACTIVE;
            ACTIVE:
                if (take && last)
                    state_nx = IDLE;
            default:
                state_nx = IDLE;
        endcase
    end

    // A sof window is (0,0) regardless of where the counters stand.
    always_comb begin
        take     = bus.win_valid
                 && (bus.win_sof || state == ACTIVE);
        cur_col  = bus.win_sof ? '0 : col;
        cur_row  = bus.win_sof ? '0 : row;
        last     = (cur_col == CW'(W - 1))
                 && (cur_row == RW'(H - 1));
        m0       = '0;
        m0.valid = take
                 && (cur_row >= RW'(4))
                 && (cur_col >= CW'(4));
        m0.sof   = m0.valid
                 && (cur_row == RW'(4))
                 && (cur_col == CW'(4));
        m0.eol   = m0.valid && (cur_col == CW'(W - 1));
        m0.done  = take && last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (take) begin
            if (cur_col == CW'(W - 1)) begin
                col <= '0;
                row <= last ? '0 : cur_row + RW'(1);
            end else begin
                col <= cur_col + CW'(1);
                row <= cur_row;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m1 <= '0;
            m2 <= '0;
        end else begin
            m1 <= m0;
            m2 <= m1;
        end
    end

    // Data stages carry no reset; stale values are masked by valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 5; i++)
            d1.rs[i] <= hsum(bus.w[5*i],   bus.w[5*i+1],
                             bus.w[5*i+2], bus.w[5*i+3],
                             bus.w[5*i+4]);
`ifdef GAUSS_BYPASS_EN
        d1.byp <= bus.bypass;
        d1.ctr <= bus.w[12];
        d2.byp <= d1.byp;
        d2.ctr <= d1.ctr;
`endif
        d2.vs <= vsum(d1.rs);
    end

    always_comb begin
        rnd    = 17'(d2.vs) + 17'd128;
        pix_nx = 8'(rnd >> 8);
`ifdef GAUSS_BYPASS_EN
        if (d2.byp)
            pix_nx = d2.ctr;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.pix_out    <= '0;
            bus.out_valid  <= 1'b0;
            bus.out_sof    <= 1'b0;
            bus.out_eol    <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.pix_out    <= pix_nx;
            bus.out_valid  <= m2.valid;
            bus.out_sof    <= m2.sof;
            bus.out_eol    <= m2.eol;
            bus.frame_done <= m2.done;
        end
    end
endmodule

// File: doc/gauss5x5_filter.md
# gauss5x5_filter

Pipelined 5x5 binomial (Gaussian) smoothing stage that consumes the 25 registered taps of the 5x5 window generator and produces one filtered 8-bit pixel per valid window. Sits directly downstream of the window generator in the satellite image pipeline. Tracks frame position with column/row counters so that only windows lying entirely inside the frame produce output. Emits frame/line markers for the next stage.

## Interface
- `W`, 3124: frame width in pixels; must match the window generator.
- `H`, 2048: frame height in lines.
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `win_valid`  in  1  taps `w0..w24` hold a new window this cycle. Aligned to the window generator's registered outputs, so it is the pixel-valid delayed one cycle.
- `win_sof`  in  1  with `win_valid`: the newest pixel (`w24`) is pixel (0,0) of a frame.
- `w0`..`w24`  in  8 each  window taps. `w0` is the oldest row and oldest column; `w24` is the newest pixel; `w12` is the centre.
- `bypass`  in  1  present only with `GAUSS_BYPASS_EN`; see Configuration.
- `pix_out`  out  8  filtered pixel.
- `out_valid`  out  1  `pix_out` valid.
- `out_sof`  out  1  first output of a frame (centre (2,2)).
- `out_eol`  out  1  last output of a line (centre column W-3).
- `frame_done`  out  1  one-cycle pulse with the last output of a frame.

## Operation
- Kernel: outer product of [1 4 6 4 1] with itself; weights sum to 256.
- Stage 1: five horizontal weighted row sums, each 12 bits unsigned (max 4080).
- Stage 2: vertical weighted sum of the row sums, 16 bits (max 65280).
- Stage 3: `pix_out = (sum + 128) >> 8`, computed at 17 bits. The result never exceeds 255, so no saturation logic is required.
- Position counters `col` (0..W-1) and `row` (0..H-1) give the coordinates of `w24`. They advance only on `win_valid`.
- Control FSM has two states:
  - IDLE: waits for a window with `win_valid & win_sof`. That window is taken as (0,0), and the FSM moves to ACTIVE. `win_valid` without `win_sof` in IDLE is ignored.
  - ACTIVE: each valid window increments `col`. When `col` is W-1 it wraps to 0 and `row` increments. The window at (H-1, W-1) is the last of the frame: it is processed and the FSM returns to IDLE.
  - `win_sof` while ACTIVE restarts the frame: counters are set to (0,0) and the FSM stays in ACTIVE. Windows already in the pipeline complete normally. `frame_done` is never issued for the aborted frame.
- A window produces output only if `row >= 4` and `col >= 4`. Its centre pixel is then (row-2, col-2). Output count per frame is (W-4)*(H-4).
- Markers travel with the data through the pipeline:
  - `out_sof` when the window is at (4,4).
  - `out_eol` when `col == W-1` and `row >= 4`.
  - `frame_done` at (H-1, W-1).

## Timing
- Latency is exactly 3 cycles from `win_valid` to `out_valid`, with full throughput of one window per cycle.
- Gaps in `win_valid` propagate unchanged as gaps in `out_valid`. Data registers may hold stale values when `out_valid` is 0.
- Reset values: `pix_out` = 0, `out_valid` = 0, `out_sof` = 0, `out_eol` = 0, `frame_done` = 0. FSM = IDLE, `col` = `row` = 0.
- Reset is allowed at any time, including mid-frame. All pipeline valid and marker bits clear on the reset edge, so no output appears in the three cycles after reset deasserts unless new valid windows enter.
- `win_sof` together with (H-1, W-1) cannot occur: `win_sof` always means (0,0).

## Configuration
- `GAUSS_BYPASS_EN` defined:
  - The `bypass` port exists. It is sampled together with `win_valid` and pipelined alongside the data.
  - When it is 1, `pix_out` is that window's `w12`, delayed 3 cycles. Valid and marker timing are identical to the filtered path.
  - Toggling `bypass` mid-frame switches output cleanly on a per-window basis.
- `GAUSS_BYPASS_EN` not defined: the port and the mux are absent, and the output is always filtered.

## Test plan
- W=8, H=6: constant-100 frame → exactly 8 `out_valid` pulses, all `pix_out` = 100. `out_sof` on the 1st pulse, `out_eol` on the 4th and 8th, `frame_done` on the 8th.
- Impulse: `w12` = 255, all other taps 0, one valid window at (4,4) → `pix_out` = 36 three cycles later.
- All taps 255 every window → `pix_out` = 255 (no overflow or wrap); taps with only `w0` = 255 → `pix_out` = 1.
- `win_valid` pattern 1,0,1,1,0 mid-frame → `out_valid` pattern 0,0,0,1,0,1,1,0.
- `win_sof` reasserted at (5,6) of a W=8, H=6 frame → counters restart. No `frame_done` for the first frame; the next full frame yields 8 outputs and one `frame_done`.
- `rst` pulsed while 3 windows are in flight → no `out_valid` afterwards; FSM ignores non-sof windows. With `GAUSS_BYPASS_EN`, `bypass` = 1 on an impulse window → `pix_out` = 255.
